// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one registered stage per power-of-two shift distance, LSB-first,
// with global-stall valid/ready flow control. Define SHIFT_STICKY_EN to build the sticky path.
module barrel_shift_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [$clog2(WIDTH)-1:0]  in_amt,
    input  logic [1:0]                in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_sticky
);
    localparam int L = $clog2(WIDTH);

    logic             adv;
    logic [L-1:0]     valid_reg;
    logic [WIDTH-1:0] data_reg [L];
    // Remaining shift bits, already aligned so that bit 0 belongs to the next stage
    logic [L-1:0]     amt_reg  [L-1];
    logic [1:0]       mode_reg [L-1];

    logic [L-1:0]     src_valid;
    logic [WIDTH-1:0] src_data [L];
    logic [L-1:0]     src_amt  [L];
    logic [1:0]       src_mode [L];
    logic [WIDTH-1:0] data_next [L];

`ifdef SHIFT_STICKY_EN
    logic [L-1:0]     sticky_reg;
    logic [L-1:0]     src_sticky;
    logic [L-1:0]     sticky_next;
`endif

    assign adv       = !(valid_reg[L-1] && !out_ready);
    assign in_ready  = adv;
    assign out_valid = valid_reg[L-1];
    assign out_data  = data_reg[L-1];

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : stage
            localparam int S = 1 << gi;
            logic [WIDTH-1:0] shifted;

            if (gi == 0) begin : head
                assign src_valid[0] = in_valid;
                assign src_data[0]  = in_data;
                assign src_amt[0]   = in_amt;
                assign src_mode[0]  = in_mode;
`ifdef SHIFT_STICKY_EN
                assign src_sticky[0] = 1'b0;
`endif
            end else begin : link
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
                assign src_amt[gi]   = amt_reg[gi-1];
                assign src_mode[gi]  = mode_reg[gi-1];
`ifdef SHIFT_STICKY_EN
                assign src_sticky[gi] = sticky_reg[gi-1];
`endif
            end

            // Arithmetic fill uses the current MSB: earlier stages already replicated the sign there
            always_comb begin
                shifted = src_data[gi];
                if (src_amt[gi][0]) begin
                    case (src_mode[gi])
                        2'b00:   shifted = {src_data[gi][WIDTH-1-S:0], {S{1'b0}}};
                        2'b01:   shifted = {{S{1'b0}}, src_data[gi][WIDTH-1:S]};
                        2'b10:   shifted = {{S{src_data[gi][WIDTH-1]}}, src_data[gi][WIDTH-1:S]};
                        default: shifted = {src_data[gi][S-1:0], src_data[gi][WIDTH-1:S]};
                    endcase
                end
            end
            assign data_next[gi] = shifted;

`ifdef SHIFT_STICKY_EN
            logic lost;
            always_comb begin
                lost = 1'b0;
                if (src_amt[gi][0]) begin
                    case (src_mode[gi])
                        2'b00:   lost = |src_data[gi][WIDTH-1 -: S];
                        2'b01,
                        2'b10:   lost = |src_data[gi][S-1:0];
                        default: lost = 1'b0;
                    endcase
                end
            end
            assign sticky_next[gi] = src_sticky[gi] | lost;
`endif
        end
    endgenerate

`ifdef SHIFT_STICKY_EN
    assign out_sticky = sticky_reg[L-1];
`else
    assign out_sticky = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int k = 0; k < L; k++) data_reg[k] <= '0;
            for (int k = 0; k < L-1; k++) begin
                amt_reg[k]  <= '0;
                mode_reg[k] <= '0;
            end
`ifdef SHIFT_STICKY_EN
            sticky_reg <= '0;
`endif
        end else if (adv) begin
            valid_reg <= src_valid;
            for (int k = 0; k < L; k++) data_reg[k] <= data_next[k];
            for (int k = 0; k < L-1; k++) begin
                amt_reg[k]  <= src_amt[k] >> 1;
                mode_reg[k] <= src_mode[k];
            end
`ifdef SHIFT_STICKY_EN
            sticky_reg <= sticky_next;
`endif
        end
    end
endmodule
